// File: rtl/dbg_guv_cmd_tx.sv
// dbg_guv_cmd_tx: head-end command injector and unclaimed-word monitor for the dbg_guv chain
// Ports:
//   clk, rst                 sole clock, asynchronous active-high reset
//   host_T{DATA,VALID,LAST}  host command stream in; host_TREADY high while the FIFO is not full
//   cmd_out_T{DATA,VALID}    registered command stream to the first dbg_guv (no backpressure)
//   chain_ret_T{DATA,VALID}  words returning from the chain tail
//   unclaimed_cnt            saturating count of returned (unclaimed) words
//   busy                     FIFO non-empty or FSM not idle
//   err_long_pkt             sticky: a packet longer than the FIFO was force-sent
//   err_timeout              sticky: a stale partial packet was flushed (DBG_GUV_CMD_TX_WDOG_EN only)
// Optional feature macro: DBG_GUV_CMD_TX_WDOG_EN (partial-packet watchdog)
module dbg_guv_cmd_tx #(
   parameter int FIFO_AW     = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int CNT_W       = 16,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      host_TDATA,
   input  logic             host_TVALID,
   output logic             host_TREADY,
   input  logic             host_TLAST,
   output logic [31:0]      cmd_out_TDATA,
   output logic             cmd_out_TVALID,
   input  logic [31:0]      chain_ret_TDATA,
   input  logic             chain_ret_TVALID,
   output logic [CNT_W-1:0] unclaimed_cnt,
   output logic             busy,
`ifdef DBG_GUV_CMD_TX_WDOG_EN
   output logic             err_timeout,
`endif
   output logic             err_long_pkt
);
   localparam int DEPTH = 2**FIFO_AW;
   localparam int PW = FIFO_AW + 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
   state_t r_state, w_state_nxt;

   logic [32:0]        r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW-1:0]      r_count, r_pkt_cnt;
   logic [GW-1:0]      r_gap;
   logic [31:0]        r_tdata;
   logic               r_tvalid, r_err_long;
   logic [CNT_W-1:0]   r_unc;
   logic [32:0]        w_rd;
   logic               w_full, w_empty, w_hs, w_push, w_pop, w_force, w_flush, w_unused;

   assign w_full  = r_count == PW'(DEPTH);
   assign w_empty = r_count == '0;
   assign w_rd    = r_mem[r_rd_ptr];
   assign w_hs    = host_TVALID & ~w_full;
   // a word handshaked in the flush cycle is accepted but discarded
   assign w_push  = w_hs & ~w_flush;
   assign w_unused = ^{chain_ret_TDATA, WDOG_CYCLES == 0};

   assign host_TREADY    = ~w_full;
   assign cmd_out_TDATA  = r_tdata;
   assign cmd_out_TVALID = r_tvalid;
   assign unclaimed_cnt  = r_unc;
   assign busy           = ~w_empty | (r_state != IDLE);
   assign err_long_pkt   = r_err_long;

`ifdef DBG_GUV_CMD_TX_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] r_wdog;
   logic          r_err_to, w_stale;
   // a full FIFO is left to the forced send, so it never ages the counter
   assign w_stale = ~w_empty & (r_pkt_cnt == '0) & (r_state == IDLE) & ~w_full;
   assign w_flush = (r_wdog == WW'(WDOG_CYCLES)) & ~w_full;
   assign err_timeout = r_err_to;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdog   <= '0;
         r_err_to <= 1'b0;
      end else begin
         r_wdog   <= (w_stale & ~w_hs & ~w_flush) ? r_wdog + 1'b1 : '0;
         r_err_to <= r_err_to | w_flush;
      end
   end
`else
   assign w_flush = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {host_TLAST, host_TDATA};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Leaving SEND (GAP_CYCLES=0) or GAP with another complete packet queued goes
   // straight back to SEND, so the inter-packet spacing is exactly GAP_CYCLES.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_force     = 1'b0;
      case (r_state)
         IDLE: begin
            w_force = w_full & (r_pkt_cnt == '0);
            if ((r_pkt_cnt != '0) | w_force) w_state_nxt = SEND;
         end
         SEND: begin
            w_pop = ~w_empty;
            if (w_pop & w_rd[32])
               w_state_nxt = (GAP_CYCLES != 0) ? GAP : (r_pkt_cnt > PW'(1)) ? SEND : IDLE;
         end
         GAP: if (r_gap == GAP_LAST) w_state_nxt = (r_pkt_cnt != '0) ? SEND : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_pkt_cnt  <= '0;
         r_gap      <= '0;
         r_tdata    <= '0;
         r_tvalid   <= 1'b0;
         r_err_long <= 1'b0;
         r_unc      <= '0;
      end else begin
         r_gap      <= (r_state == GAP) ? r_gap + 1'b1 : '0;
         r_tvalid   <= w_pop;
         r_err_long <= r_err_long | w_force;
         if (w_pop) r_tdata <= w_rd[31:0];
         if (chain_ret_TVALID && r_unc != '1) r_unc <= r_unc + 1'b1;
         if (w_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pkt_cnt <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count   <= r_count + PW'(w_push) - PW'(w_pop);
            r_pkt_cnt <= r_pkt_cnt + PW'(w_push & host_TLAST) - PW'(w_pop & w_rd[32]);
         end
      end
   end
endmodule
